// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the unified I/D memory port arbiter: FSM state
// encodings and default widths. The hazard unit and the debug bus decode
// the exported state through these same constants.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE     = 2'd0;
  localparam logic [1:0] ARB_IF_WAIT  = 2'd1;
  localparam logic [1:0] ARB_MEM_WAIT = 2'd2;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_CNT_W  = 32;

endpackage

// File: rtl/stall_counter.sv
// stall_counter
// Free-running cycle counter. It adds one on every clock where en is high
// and wraps modulo 2^CNT_W.
// Ports:
//   clk   - clock
//   rstn  - asynchronous active-low reset, clears the count
//   en    - count enable (a stall indication)
//   o_cnt - current count
module stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Sequencer for the single-ported unified instruction/data memory. It grants
// the port either to the IF-stage fetch or to the MEM-stage load/store, and
// runs one variable-latency transaction at a time. It returns completion
// strobes and stall requests, and exports stall-cycle counters.
// Ports:
//   clk, rstn                 - clock, async active-low reset
//   if_req/if_addr/if_flush   - fetch request, PC, jump-taken discard
//   if_ready/if_rdata         - fetch completion strobe and instruction word
//   mem_rd_req/mem_wr_req     - load/store request (mutually exclusive)
//   mem_addr/mem_wdata        - data address and store data
//   mem_ready/mem_rdata       - load/store completion strobe and load data
//   m_re/m_we/m_addr/m_wdata  - memory command (one-cycle pulse) and payload
//   m_valid/m_rdata           - memory response/ack and read data
//   IF_stall_mem/MEM_stall    - stall requests to pipeline control
//   if_stall_cnt/mem_stall_cnt- stall-cycle counters for the debug bus
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int CNT_W  = ARB_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              m_re,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_valid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              IF_stall_mem,
  output logic              MEM_stall,
  output logic [CNT_W-1:0]  if_stall_cnt,
  output logic [CNT_W-1:0]  mem_stall_cnt
);

  logic [1:0]        r_state;
  logic              r_discard;
  logic              r_m_re;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;

  logic w_mem_req;
  logic w_if_ready;
  logic w_mem_ready;

  assign w_mem_req = mem_rd_req | mem_wr_req;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ARB_IDLE;
      r_discard <= 1'b0;
      r_m_re    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end else begin
      // Commands are single-cycle pulses: only the grant cycle raises them.
      r_m_re <= 1'b0;
      r_m_we <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          // MEM belongs to the older instruction, so it always wins.
          if (w_mem_req) begin
            r_m_re   <= mem_rd_req;
            r_m_we   <= mem_wr_req;
            r_m_addr <= mem_addr;
            if (mem_wr_req) begin
              r_m_wdata <= mem_wdata;
            end
            r_state <= ARB_MEM_WAIT;
          end else if (if_req && !if_flush) begin
            r_m_re   <= 1'b1;
            r_m_addr <= if_addr;
            r_state  <= ARB_IF_WAIT;
          end
        end
        ARB_IF_WAIT: begin
          // A flush cannot abort the access; it only hides its result.
          if (m_valid) begin
            r_discard <= 1'b0;
            r_state   <= ARB_IDLE;
          end else if (if_flush) begin
            r_discard <= 1'b1;
          end
        end
        ARB_MEM_WAIT: begin
          if (m_valid) begin
            r_state <= ARB_IDLE;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Completion is combinational from m_valid; a flush in the response
  // cycle itself must also suppress the strobe.
  assign w_if_ready  = (r_state == ARB_IF_WAIT) && m_valid && !r_discard && !if_flush;
  assign w_mem_ready = (r_state == ARB_MEM_WAIT) && m_valid;

  assign if_ready  = w_if_ready;
  assign mem_ready = w_mem_ready;
  assign if_rdata  = m_rdata;
  assign mem_rdata = m_rdata;

  assign m_re    = r_m_re;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;

  assign IF_stall_mem = if_req && !w_if_ready;
  assign MEM_stall    = w_mem_req && !w_mem_ready;

  stall_counter #(.CNT_W(CNT_W)) u_if_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .en    (IF_stall_mem),
    .o_cnt (if_stall_cnt)
  );

  stall_counter #(.CNT_W(CNT_W)) u_mem_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .en    (MEM_stall),
    .o_cnt (mem_stall_cnt)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          mem_rd_req;
  logic          mem_wr_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          m_re;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_valid;
  logic [DW-1:0] m_rdata;
  logic          IF_stall_mem;
  logic          MEM_stall;
  logic [CW-1:0] if_stall_cnt;
  logic [CW-1:0] mem_stall_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_flush      (if_flush),
    .if_ready      (if_ready),
    .if_rdata      (if_rdata),
    .mem_rd_req    (mem_rd_req),
    .mem_wr_req    (mem_wr_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .m_re          (m_re),
    .m_we          (m_we),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_valid       (m_valid),
    .m_rdata       (m_rdata),
    .IF_stall_mem  (IF_stall_mem),
    .MEM_stall     (MEM_stall),
    .if_stall_cnt  (if_stall_cnt),
    .mem_stall_cnt (mem_stall_cnt)
  );

  // Memory model: m_valid exactly lat_cur cycles after a command, data
  // from mem_data. Shares rstn, so an outstanding response is dropped.
  int            lat_cur;
  int            mcnt;
  logic [DW-1:0] mem_data;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) mcnt <= 0;
    else if (m_re || m_we) mcnt <= lat_cur;
    else if (mcnt != 0) mcnt <= mcnt - 1;
  end

  assign m_valid = (mcnt == 1);
  assign m_rdata = mem_data;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          lat;
    logic        ifr;
    logic [31:0] ifa;
    logic        fl;
    logic        mrd;
    logic        mwr;
    logic [31:0] ma;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        e_re;
    logic        e_we;
    logic [31:0] e_a;
    logic        e_ifr;
    logic        e_mr;
    logic        e_ifs;
    logic        e_ms;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input int lat, input logic ifr, input logic [31:0] ifa, input logic fl,
                     input logic mrd, input logic mwr, input logic [31:0] ma,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input logic e_re, input logic e_we, input logic [31:0] e_a,
                     input logic e_ifr, input logic e_mr, input logic e_ifs, input logic e_ms);
    vec_t v;
    v.lat = lat; v.ifr = ifr; v.ifa = ifa; v.fl = fl; v.mrd = mrd; v.mwr = mwr;
    v.ma = ma; v.wd = wd; v.rd = rd; v.e_re = e_re; v.e_we = e_we; v.e_a = e_a;
    v.e_ifr = e_ifr; v.e_mr = e_mr; v.e_ifs = e_ifs; v.e_ms = e_ms;
    vecs.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_flush = 0; mem_rd_req = 0; mem_wr_req = 0;
  endtask

  int acc_if;
  int acc_mem;

  initial begin
    rstn = 0; if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_data = 0; lat_cur = 1;
    idle_inputs();
    if_req = 1;

    // ---------------- reset state ----------------
    @(negedge clk);
    @(negedge clk);
    chk("rst_m_re", 64'(m_re), 64'd0);
    chk("rst_m_we", 64'(m_we), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_m_wdata", 64'(m_wdata), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    chk("rst_if_cnt", 64'(if_stall_cnt), 64'd0);
    chk("rst_mem_cnt", 64'(mem_stall_cnt), 64'd0);
    chk("rst_if_stall_eq", 64'(IF_stall_mem), 64'd1);
    if_req = 0;
    cyc();
    rstn = 1;

    // ---------------- vector table ----------------
    // single fetch, L=1
    row(1, 1, 32'h10, 0, 0, 0, 0, 0, 32'h0010_0093,  0, 0, 0,       0, 0, 1, 0);
    row(1, 1, 32'h10, 0, 0, 0, 0, 0, 32'h0010_0093,  1, 0, 32'h10,  0, 0, 1, 0);
    row(1, 1, 32'h10, 0, 0, 0, 0, 0, 32'h0010_0093,  0, 0, 0,       1, 0, 0, 0);
    row(1, 0, 32'h10, 0, 0, 0, 0, 0, 32'h0010_0093,  0, 0, 0,       0, 0, 0, 0);
    // contention, L=3: load first, then fetch after one idle bubble
    row(3, 1, 32'h40, 0, 1, 0, 32'h2000, 0, 32'hCAFE_0001,  0, 0, 0,         0, 0, 1, 1);
    row(3, 1, 32'h40, 0, 1, 0, 32'h2000, 0, 32'hCAFE_0001,  1, 0, 32'h2000,  0, 0, 1, 1);
    row(3, 1, 32'h40, 0, 1, 0, 32'h2000, 0, 32'hCAFE_0001,  0, 0, 0,         0, 0, 1, 1);
    row(3, 1, 32'h40, 0, 1, 0, 32'h2000, 0, 32'hCAFE_0001,  0, 0, 0,         0, 0, 1, 1);
    row(3, 1, 32'h40, 0, 1, 0, 32'h2000, 0, 32'hCAFE_0001,  0, 0, 0,         0, 1, 1, 0);
    row(3, 1, 32'h40, 0, 0, 0, 32'h2000, 0, 32'hCAFE_0001,  0, 0, 0,         0, 0, 1, 0);
    row(3, 1, 32'h40, 0, 0, 0, 32'h2000, 0, 32'hCAFE_0001,  1, 0, 32'h40,    0, 0, 1, 0);
    row(3, 1, 32'h40, 0, 0, 0, 32'h2000, 0, 32'hCAFE_0001,  0, 0, 0,         0, 0, 1, 0);
    row(3, 1, 32'h40, 0, 0, 0, 32'h2000, 0, 32'hCAFE_0001,  0, 0, 0,         0, 0, 1, 0);
    row(3, 1, 32'h40, 0, 0, 0, 32'h2000, 0, 32'hCAFE_0001,  0, 0, 0,         1, 0, 0, 0);
    row(3, 0, 32'h40, 0, 0, 0, 32'h2000, 0, 32'hCAFE_0001,  0, 0, 0,         0, 0, 0, 0);
    // store, L=2
    row(2, 0, 0, 0, 0, 1, 32'h3004, 32'hDEAD_BEEF, 32'h1234_5678,  0, 0, 0,        0, 0, 0, 1);
    row(2, 0, 0, 0, 0, 1, 32'h3004, 32'hDEAD_BEEF, 32'h1234_5678,  0, 1, 32'h3004, 0, 0, 0, 1);
    row(2, 0, 0, 0, 0, 1, 32'h3004, 32'hDEAD_BEEF, 32'h1234_5678,  0, 0, 0,        0, 0, 0, 1);
    row(2, 0, 0, 0, 0, 1, 32'h3004, 32'hDEAD_BEEF, 32'h1234_5678,  0, 0, 0,        0, 1, 0, 0);
    row(2, 0, 0, 0, 0, 0, 32'h3004, 32'hDEAD_BEEF, 32'h1234_5678,  0, 0, 0,        0, 0, 0, 0);
    // flush in IDLE suppresses only that cycle's grant, L=1
    row(1, 1, 32'h80, 1, 0, 0, 0, 0, 32'h0000_0013,  0, 0, 0,       0, 0, 1, 0);
    row(1, 1, 32'h80, 0, 0, 0, 0, 0, 32'h0000_0013,  0, 0, 0,       0, 0, 1, 0);
    row(1, 1, 32'h80, 0, 0, 0, 0, 0, 32'h0000_0013,  1, 0, 32'h80,  0, 0, 1, 0);
    row(1, 1, 32'h80, 0, 0, 0, 0, 0, 32'h0000_0013,  0, 0, 0,       1, 0, 0, 0);
    row(1, 0, 32'h80, 0, 0, 0, 0, 0, 32'h0000_0013,  0, 0, 0,       0, 0, 0, 0);
    // MEM request arriving during IF_WAIT waits for the fetch, L=2
    row(2, 1, 32'h200, 0, 0, 0, 32'h100, 0, 32'h55AA_55AA,  0, 0, 0,        0, 0, 1, 0);
    row(2, 1, 32'h200, 0, 1, 0, 32'h100, 0, 32'h55AA_55AA,  1, 0, 32'h200,  0, 0, 1, 1);
    row(2, 1, 32'h200, 0, 1, 0, 32'h100, 0, 32'h55AA_55AA,  0, 0, 0,        0, 0, 1, 1);
    row(2, 1, 32'h200, 0, 1, 0, 32'h100, 0, 32'h55AA_55AA,  0, 0, 0,        1, 0, 0, 1);
    row(2, 0, 32'h200, 0, 1, 0, 32'h100, 0, 32'h55AA_55AA,  0, 0, 0,        0, 0, 0, 1);
    row(2, 0, 32'h200, 0, 1, 0, 32'h100, 0, 32'h55AA_55AA,  1, 0, 32'h100,  0, 0, 0, 1);
    row(2, 0, 32'h200, 0, 1, 0, 32'h100, 0, 32'h55AA_55AA,  0, 0, 0,        0, 0, 0, 1);
    row(2, 0, 32'h200, 0, 1, 0, 32'h100, 0, 32'h55AA_55AA,  0, 0, 0,        0, 1, 0, 0);
    row(2, 0, 32'h200, 0, 0, 0, 32'h100, 0, 32'h55AA_55AA,  0, 0, 0,        0, 0, 0, 0);

    acc_if = 0;
    acc_mem = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      cyc();
      lat_cur = vecs[i].lat; if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
      if_flush = vecs[i].fl; mem_rd_req = vecs[i].mrd; mem_wr_req = vecs[i].mwr;
      mem_addr = vecs[i].ma; mem_wdata = vecs[i].wd; mem_data = vecs[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d_m_re", i), 64'(m_re), 64'(vecs[i].e_re));
      chk($sformatf("v%0d_m_we", i), 64'(m_we), 64'(vecs[i].e_we));
      if (vecs[i].e_re || vecs[i].e_we)
        chk($sformatf("v%0d_m_addr", i), 64'(m_addr), 64'(vecs[i].e_a));
      if (vecs[i].e_we)
        chk($sformatf("v%0d_m_wdata", i), 64'(m_wdata), 64'(vecs[i].wd));
      chk($sformatf("v%0d_if_ready", i), 64'(if_ready), 64'(vecs[i].e_ifr));
      if (vecs[i].e_ifr)
        chk($sformatf("v%0d_if_rdata", i), 64'(if_rdata), 64'(vecs[i].rd));
      chk($sformatf("v%0d_mem_ready", i), 64'(mem_ready), 64'(vecs[i].e_mr));
      if (vecs[i].e_mr && vecs[i].mrd)
        chk($sformatf("v%0d_mem_rdata", i), 64'(mem_rdata), 64'(vecs[i].rd));
      chk($sformatf("v%0d_if_stall", i), 64'(IF_stall_mem), 64'(vecs[i].e_ifs));
      chk($sformatf("v%0d_mem_stall", i), 64'(MEM_stall), 64'(vecs[i].e_ms));
      // Counters hold the number of earlier stall cycles, modulo 16.
      chk($sformatf("v%0d_if_cnt", i), 64'(if_stall_cnt), 64'(acc_if % 16));
      chk($sformatf("v%0d_mem_cnt", i), 64'(mem_stall_cnt), 64'(acc_mem % 16));
      acc_if += int'(vecs[i].e_ifs);
      acc_mem += int'(vecs[i].e_ms);
    end

    // ---------------- flush in the m_valid cycle, L=2 ----------------
    lat_cur = 2; mem_data = 32'h1111_1111;
    cyc(); if_req = 1; if_addr = 32'h500;
    @(negedge clk);
    cyc(); @(negedge clk);
    chk("fv_grant", 64'(m_re), 64'd1);
    chk("fv_grant_addr", 64'(m_addr), 64'h500);
    cyc(); @(negedge clk);
    cyc(); if_flush = 1; if_addr = 32'h600; @(negedge clk);
    chk("fv_valid_seen", 64'(m_valid), 64'd1);
    chk("fv_if_ready_suppressed", 64'(if_ready), 64'd0);
    cyc(); if_flush = 0; @(negedge clk);
    chk("fv_bubble_no_cmd", 64'(m_re), 64'd0);
    cyc(); @(negedge clk);
    chk("fv_refetch", 64'(m_re), 64'd1);
    chk("fv_refetch_addr", 64'(m_addr), 64'h600);
    cyc(); @(negedge clk);
    cyc(); @(negedge clk);
    chk("fv_refetch_ready", 64'(if_ready), 64'd1);
    chk("fv_refetch_rdata", 64'(if_rdata), 64'h1111_1111);
    cyc(); idle_inputs();

    // ---------------- flush earlier in IF_WAIT, L=3 ----------------
    lat_cur = 3; mem_data = 32'h2222_2222;
    cyc(); if_req = 1; if_addr = 32'h700;
    cyc();
    cyc(); if_flush = 1; if_addr = 32'h704;
    cyc(); if_flush = 0;
    cyc(); @(negedge clk);
    chk("df_valid_seen", 64'(m_valid), 64'd1);
    chk("df_discarded", 64'(if_ready), 64'd0);
    cyc();
    cyc(); @(negedge clk);
    chk("df_refetch_addr", 64'(m_addr), 64'h704);
    chk("df_refetch_re", 64'(m_re), 64'd1);
    cyc(); cyc(); cyc(); @(negedge clk);
    chk("df_flag_cleared", 64'(if_ready), 64'd1);
    cyc(); idle_inputs();

    // ---------------- reset mid-access ----------------
    lat_cur = 5;
    cyc(); mem_wr_req = 1; mem_addr = 32'h3008; mem_wdata = 32'hA5A5_A5A5;
    cyc(); @(negedge clk);
    chk("ra_we_before", 64'(m_we), 64'd1);
    cyc(); #2 rstn = 0; #1;
    chk("ra_m_we", 64'(m_we), 64'd0);
    chk("ra_m_addr", 64'(m_addr), 64'd0);
    chk("ra_m_wdata", 64'(m_wdata), 64'd0);
    chk("ra_mem_ready", 64'(mem_ready), 64'd0);
    chk("ra_if_cnt", 64'(if_stall_cnt), 64'd0);
    chk("ra_mem_cnt", 64'(mem_stall_cnt), 64'd0);
    chk("ra_mem_stall_eq", 64'(MEM_stall), 64'd1);
    idle_inputs();
    cyc(); cyc();
    rstn = 1;

    // ---------------- counter wrap, 17 stall cycles ----------------
    lat_cur = 30;
    cyc(); if_req = 1; if_addr = 32'h900;
    for (int k = 0; k < 17; k++) cyc();
    @(negedge clk);
    chk("wrap_if_cnt", 64'(if_stall_cnt), 64'd1);
    chk("wrap_still_stalled", 64'(IF_stall_mem), 64'd1);
    idle_inputs();
    rstn = 0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
